// File: rtl/instr_sequencer_if.sv
// Program-load, control and processor-facing signals of the instruction sequencer.
// The master side loads and starts programs and drives the processor bus; the slave side is the sequencer.
interface instr_sequencer_if #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned ADDR_W = 4
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic [ADDR_W:0]   prog_len;
  logic              start;
  logic [WIDTH-1:0]  bus;
  logic [WIDTH-1:0]  iin;
  logic [ADDR_W-1:0] pc;
  logic              busy;
  logic              done;
  logic [WIDTH-1:0]  result;
  logic              result_valid;

  modport master (
    output wr_en, wr_addr, wr_data, prog_len, start, bus,
    input  iin, pc, busy, done, result, result_valid
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, prog_len, start, bus,
    output iin, pc, busy, done, result, result_valid
  );
endinterface

// File: rtl/instr_sequencer.sv
// Steps a loaded program onto the processor's iin, one instruction per fixed slot,
// capturing the processor bus at the end of each slot and flagging completion.
module instr_sequencer #(
  parameter int unsigned      WIDTH       = 16,
  parameter int unsigned      DEPTH       = 16,
  parameter int unsigned      ADDR_W      = 4,
  parameter int unsigned      SLOT_CYCLES = 4,
  parameter logic [WIDTH-1:0] IDLE_WORD   = '0
) (
  input logic         clock,
  input logic         resetn,
  instr_sequencer_if.slave sif
);

  localparam int unsigned CNT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int unsigned LEN_W = ADDR_W + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  state_t            state, state_d;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [LEN_W-1:0]  len, len_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [ADDR_W-1:0] pc, pc_d;
  logic [WIDTH-1:0]  iin, iin_d;
  logic [WIDTH-1:0]  result, result_d;
  logic              busy, busy_d;
  logic              done, done_d;
  logic              result_valid, result_valid_d;

  logic [LEN_W-1:0]  len_clamped;
  logic [ADDR_W-1:0] pc_next;
  logic              slot_end;
  logic              last;

  assign len_clamped = (sif.prog_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : sif.prog_len;
  assign pc_next     = pc + ADDR_W'(1);
  assign slot_end    = (cnt == CNT_W'(SLOT_CYCLES - 1));
  assign last        = (LEN_W'(pc) == (len - LEN_W'(1)));

  // Program memory is deliberately left out of reset so a reset keeps the loaded program.
  always_ff @(posedge clock) begin
    if (sif.wr_en && (state == IDLE)) begin
      mem[sif.wr_addr] <= sif.wr_data;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      len          <= '0;
      cnt          <= '0;
      pc           <= '0;
      iin          <= IDLE_WORD;
      result       <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      state        <= state_d;
      len          <= len_d;
      cnt          <= cnt_d;
      pc           <= pc_d;
      iin          <= iin_d;
      result       <= result_d;
      busy         <= busy_d;
      done         <= done_d;
      result_valid <= result_valid_d;
    end
  end

  // Next-state and next-output values; outputs are computed one edge early so they stay registered.
  always_comb begin
    state_d        = state;
    len_d          = len;
    cnt_d          = cnt;
    pc_d           = pc;
    iin_d          = iin;
    result_d       = result;
    busy_d         = busy;
    done_d         = 1'b0;
    result_valid_d = 1'b0;

    case (state)
      IDLE: begin
        busy_d = 1'b0;
        iin_d  = IDLE_WORD;
        if (sif.start) begin
          len_d = len_clamped;
          if (len_clamped == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ISSUE;
            busy_d  = 1'b1;
            pc_d    = '0;
            iin_d   = mem[0];
            cnt_d   = '0;
          end
        end
      end

      ISSUE: begin
        cnt_d = cnt + CNT_W'(1);
        if (slot_end) begin
          result_d       = sif.bus;
          result_valid_d = 1'b1;
          cnt_d          = '0;
          if (last) begin
            state_d = DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            iin_d   = IDLE_WORD;
          end else begin
            pc_d  = pc_next;
            iin_d = mem[pc_next];
          end
        end
      end

      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        iin_d   = IDLE_WORD;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        iin_d   = IDLE_WORD;
      end
    endcase
  end

  assign sif.iin          = iin;
  assign sif.pc           = pc;
  assign sif.busy         = busy;
  assign sif.done         = done;
  assign sif.result       = result;
  assign sif.result_valid = result_valid;

endmodule
